// File: rtl/modular_square_iter_wrapper_if.sv
// Host-side bus of the modular squaring iteration wrapper.
// The abort signal exists only when MSW_ABORT_EN is defined.
interface modular_square_iter_wrapper_if #(
  parameter int unsigned MOD_LEN       = 1024,
  parameter int unsigned NUM_ELEMENTS  = 66,
  parameter int unsigned OUT_COEF_BITS = 32,
  parameter int unsigned ITER_W        = 64
);
  logic                                  start;
  logic [MOD_LEN-1:0]                    sq_in;
  logic [ITER_W-1:0]                     t_iters;
  logic                                  busy;
  logic [NUM_ELEMENTS*OUT_COEF_BITS-1:0] sq_out;
  logic                                  sq_out_valid;
  logic [ITER_W-1:0]                     iter_count;
  logic                                  done;
`ifdef MSW_ABORT_EN
  logic                                  abort;
`endif

  modport master (
`ifdef MSW_ABORT_EN
    output abort,
`endif
    output start, sq_in, t_iters,
    input  busy, sq_out, sq_out_valid, iter_count, done
  );

  modport slave (
`ifdef MSW_ABORT_EN
    input  abort,
`endif
    input  start, sq_in, t_iters,
    output busy, sq_out, sq_out_valid, iter_count, done
  );
endinterface

// File: rtl/modular_square_iter_wrapper.sv
// IO wrapper and iteration controller for a modular squaring core.
// Converts sq_in into core coefficients, launches the core through an input
// pipe, counts results arriving through an output pipe and finishes after
// t_iters results. Optional feature macro: MSW_ABORT_EN (adds bus.abort).
module modular_square_iter_wrapper #(
  parameter int unsigned MOD_LEN            = 1024,
  parameter int unsigned WORD_LEN           = 16,
  parameter int unsigned BIT_LEN            = 17,
  parameter int unsigned REDUNDANT_ELEMENTS = 2,
  parameter int unsigned IN_STAGES          = 3,
  parameter int unsigned OUT_STAGES         = 3,
  parameter int unsigned ITER_W             = 64,
  parameter int unsigned OUT_COEF_BITS      = 32,
  localparam int unsigned NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
  localparam int unsigned NUM_ELEMENTS = NONREDUNDANT_ELEMENTS + REDUNDANT_ELEMENTS,
  localparam int unsigned CORE_W       = NUM_ELEMENTS * BIT_LEN,
  localparam int unsigned OUT_W        = NUM_ELEMENTS * OUT_COEF_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  modular_square_iter_wrapper_if.slave  bus,
  output logic                          o_core_reset_c,
  output logic                          o_core_start,
  output logic [CORE_W-1:0]             o_core_sq_in,
  input  logic                          i_core_valid,
  input  logic [CORE_W-1:0]             i_core_sq_out
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_abort;
  logic                w_abort_take;
  logic                w_accept;
  logic                w_zero;
  logic                w_count;
  logic                w_last;
  logic [CORE_W-1:0]   w_conv_core;
  logic [OUT_W-1:0]    w_conv_out;
  logic                w_em_vld;
  logic [CORE_W-1:0]   w_em_data;
  logic [OUT_W-1:0]    w_em_out;

  logic [IN_STAGES-1:0] r_start_pipe;
  logic [CORE_W-1:0]    r_in_data [IN_STAGES];
  logic                 r_busy;
  logic [OUT_W-1:0]     r_sq_out;
  logic                 r_sq_out_valid;
  logic [ITER_W-1:0]    r_iter_count;
  logic [ITER_W-1:0]    r_t_iters;
  logic                 r_done;

`ifdef MSW_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_abort_take   = w_abort && (r_state == S_LOAD || r_state == S_RUN);
  assign w_accept       = (r_state == S_IDLE) && bus.start && (bus.t_iters != '0);
  assign w_zero         = (r_state == S_IDLE) && bus.start && (bus.t_iters == '0);
  assign w_count        = (r_state == S_RUN) && w_em_vld && !w_abort_take;
  assign w_last         = w_count && ((r_iter_count + ITER_W'(1)) == r_t_iters);
  assign o_core_reset_c = reset || (r_state == S_IDLE) || (r_state == S_DONE);
  assign o_core_start   = r_start_pipe[IN_STAGES-1];
  assign o_core_sq_in   = r_in_data[IN_STAGES-1];

  // Split sq_in into WORD_LEN slices, widened for the core and for sq_out
  always_comb begin
    w_conv_core = '0;
    w_conv_out  = '0;
    for (int unsigned j = 0; j < NONREDUNDANT_ELEMENTS; j++) begin
      w_conv_core[j*BIT_LEN +: BIT_LEN] = BIT_LEN'(bus.sq_in[j*WORD_LEN +: WORD_LEN]);
      w_conv_out[j*OUT_COEF_BITS +: OUT_COEF_BITS] =
        OUT_COEF_BITS'(bus.sq_in[j*WORD_LEN +: WORD_LEN]);
    end
  end

  // Zero-extend each core coefficient into its sq_out field
  always_comb begin
    w_em_out = '0;
    for (int unsigned j = 0; j < NUM_ELEMENTS; j++) begin
      w_em_out[j*OUT_COEF_BITS +: OUT_COEF_BITS] =
        OUT_COEF_BITS'(w_em_data[j*BIT_LEN +: BIT_LEN]);
    end
  end

  // Input pipe: start token and converted operand travel together
  always_ff @(posedge clk) begin
    if (reset || w_abort_take) begin
      r_start_pipe <= '0;
    end else begin
      r_start_pipe <= (r_start_pipe << 1) | IN_STAGES'(w_accept);
    end
    if (w_accept) begin
      r_in_data[0] <= w_conv_core;
    end
    for (int k = 1; k < IN_STAGES; k++) begin
      r_in_data[k] <= r_in_data[k-1];
    end
  end

  // Output pipe; valids are flushed while the core is held in reset
  if (OUT_STAGES == 1) begin : g_out_direct
    assign w_em_vld  = i_core_valid;
    assign w_em_data = i_core_sq_out;
  end else begin : g_out_pipe
    localparam int unsigned P = OUT_STAGES - 1;
    logic [P-1:0]      r_vld;
    logic [CORE_W-1:0] r_data [P];

    // Shift core results towards the sq_out register
    always_ff @(posedge clk) begin
      if (o_core_reset_c || w_abort_take) begin
        r_vld <= '0;
      end else begin
        r_vld <= (r_vld << 1) | P'(i_core_valid);
      end
      r_data[0] <= i_core_sq_out;
      for (int k = 1; k < int'(P); k++) begin
        r_data[k] <= r_data[k-1];
      end
    end

    assign w_em_vld  = r_vld[P-1];
    assign w_em_data = r_data[P-1];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_abort_take)                    w_state_nxt = S_IDLE;
        else if (r_start_pipe[IN_STAGES-1])  w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_abort_take) w_state_nxt = S_IDLE;
        else if (w_last)  w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Host-visible outputs, run length and result counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy         <= 1'b0;
      r_sq_out       <= '0;
      r_sq_out_valid <= 1'b0;
      r_iter_count   <= '0;
      r_t_iters      <= '0;
      r_done         <= 1'b0;
    end else begin
      r_busy         <= (w_state_nxt != S_IDLE);
      r_sq_out_valid <= w_count;
      r_done         <= w_last || w_zero;
      if (w_accept) begin
        r_t_iters <= bus.t_iters;
      end
      if (w_accept || w_zero) begin
        r_iter_count <= '0;
      end else if (w_count) begin
        r_iter_count <= r_iter_count + ITER_W'(1);
      end
      if (w_zero) begin
        r_sq_out <= w_conv_out;
      end else if (w_count) begin
        r_sq_out <= w_em_out;
      end
    end
  end

  assign bus.busy         = r_busy;
  assign bus.sq_out       = r_sq_out;
  assign bus.sq_out_valid = r_sq_out_valid;
  assign bus.iter_count   = r_iter_count;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_modular_square_iter_wrapper.sv
// Bench for modular_square_iter_wrapper: a behavioural squaring core
// (one result every two cycles, redundant carry in coefficient 0) plus a
// table of directed runs and hand-written reset / restart / abort sequences.
`timescale 1ns/1ps
module tb_modular_square_iter_wrapper;
  localparam int unsigned MOD_LEN  = 1024;
  localparam int unsigned WORD_LEN = 16;
  localparam int unsigned BIT_LEN  = 17;
  localparam int unsigned NR       = 64;
  localparam int unsigned NUM_EL   = 66;
  localparam int unsigned OCB      = 32;
  localparam int unsigned ITER_W   = 64;
  localparam int unsigned CORE_W   = NUM_EL * BIT_LEN;
  localparam int unsigned OUT_W    = NUM_EL * OCB;
  localparam int unsigned VW       = 1088;

  typedef struct {
    string              name;
    logic [MOD_LEN-1:0] x;
    logic [ITER_W-1:0]  t;
    logic [VW-1:0]      exp_final;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  modular_square_iter_wrapper_if bus ();

  logic              core_reset;
  logic              core_start;
  logic [CORE_W-1:0] core_sq_in;
  logic              core_valid;
  logic [CORE_W-1:0] core_sq_out;

  modular_square_iter_wrapper dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .o_core_reset_c (core_reset),
    .o_core_start   (core_start),
    .o_core_sq_in   (core_sq_in),
    .i_core_valid   (core_valid),
    .i_core_sq_out  (core_sq_out)
  );

  logic [MOD_LEN-1:0] modn;
  int                 n_chk = 0;
  int                 n_pass = 0;
  logic [MOD_LEN-1:0] mon_exp;
  int                 mon_k, mon_done, mon_late;
  bit                 mon_busy;

  function automatic logic [MOD_LEN-1:0] sqmod(input logic [MOD_LEN-1:0] v);
    logic [2*MOD_LEN-1:0] p;
    p = {{MOD_LEN{1'b0}}, v} * {{MOD_LEN{1'b0}}, v};
    p = p % {{MOD_LEN{1'b0}}, modn};
    return p[MOD_LEN-1:0];
  endfunction

  function automatic logic [MOD_LEN-1:0] pow2k(input logic [MOD_LEN-1:0] x, input int k);
    logic [MOD_LEN-1:0] v;
    v = x;
    for (int i = 0; i < k; i++) v = sqmod(v);
    return v;
  endfunction

  function automatic logic [VW-1:0] decode_out(input logic [OUT_W-1:0] s);
    logic [VW-1:0] acc;
    acc = '0;
    for (int j = 0; j < NUM_EL; j++) acc = acc + (VW'(s[j*OCB +: OCB]) << (WORD_LEN*j));
    return acc;
  endfunction

  function automatic logic [VW-1:0] decode_core(input logic [CORE_W-1:0] s);
    logic [VW-1:0] acc;
    acc = '0;
    for (int j = 0; j < NUM_EL; j++) acc = acc + (VW'(s[j*BIT_LEN +: BIT_LEN]) << (WORD_LEN*j));
    return acc;
  endfunction

  // Non-redundant words, with one unit borrowed from coef 1 into coef 0's bit 16
  function automatic logic [CORE_W-1:0] encode_core(input logic [MOD_LEN-1:0] v);
    logic [CORE_W-1:0]  c;
    logic [BIT_LEN-1:0] c0, c1;
    c = '0;
    for (int j = 0; j < NR; j++) c[j*BIT_LEN +: BIT_LEN] = BIT_LEN'(v[j*WORD_LEN +: WORD_LEN]);
    c0 = c[0 +: BIT_LEN];
    c1 = c[BIT_LEN +: BIT_LEN];
    if (c1 != '0) begin
      c[0 +: BIT_LEN]       = c0 + BIT_LEN'(17'h10000);
      c[BIT_LEN +: BIT_LEN] = c1 - BIT_LEN'(1);
    end
    return c;
  endfunction

  // Behavioural core: loads on start, then one squaring every two cycles
  logic [MOD_LEN-1:0] core_val;
  logic               core_run, core_ph;
  always @(posedge clk) begin
    if (core_reset) begin
      core_run   <= 1'b0;
      core_ph    <= 1'b0;
      core_valid <= 1'b0;
    end else if (core_start) begin
      core_val   <= MOD_LEN'(decode_core(core_sq_in));
      core_run   <= 1'b1;
      core_ph    <= 1'b0;
      core_valid <= 1'b0;
    end else if (core_run) begin
      core_ph <= ~core_ph;
      if (core_ph) begin
        core_val    <= sqmod(core_val);
        core_sq_out <= encode_core(sqmod(core_val));
        core_valid  <= 1'b1;
      end else begin
        core_valid <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (low 192 bits)", name, got[191:0], exp[191:0]);
  endtask

  // Per-cycle monitor: every valid must carry the next square and count
  task automatic sample();
    if (bus.busy) mon_busy = 1'b1;
    if (bus.sq_out_valid) begin
      if (mon_done != 0) mon_late++;
      mon_k++;
      mon_exp = sqmod(mon_exp);
      check("sq_out_value", decode_out(bus.sq_out), VW'(mon_exp));
      check("iter_count_step", VW'(bus.iter_count), VW'(mon_k));
    end
    if (bus.done) mon_done++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  task automatic launch(input logic [MOD_LEN-1:0] x, input logic [ITER_W-1:0] t);
    bus.sq_in   = x;
    bus.t_iters = t;
    bus.start   = 1'b1;
    mon_exp  = x;
    mon_k    = 0;
    mon_done = 0;
    mon_late = 0;
    mon_busy = 1'b0;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic finish_run(input string name, input logic [ITER_W-1:0] t,
                            input logic [VW-1:0] exp_final);
    int cyc;
    cyc = 0;
    while (mon_done == 0 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check({name, "_done_seen"}, VW'(mon_done), VW'(1));
    check({name, "_busy_at_done"}, VW'(bus.busy), VW'(t != 0));
    check({name, "_final_value"}, decode_out(bus.sq_out), exp_final);
    check({name, "_iter_count"}, VW'(bus.iter_count), VW'(t));
    tick();
    check({name, "_busy_after"}, VW'(bus.busy), VW'(0));
    repeat (12) tick();
    check({name, "_valid_count"}, VW'(mon_k), VW'(t));
    check({name, "_late_valids"}, VW'(mon_late), VW'(0));
    check({name, "_held_value"}, decode_out(bus.sq_out), exp_final);
    if (t == 0) check({name, "_busy_never"}, VW'(mon_busy), VW'(0));
  endtask

  task automatic wait_k(input int k);
    int cyc;
    cyc = 0;
    while (mon_k < k && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("wait_iteration", VW'(mon_k), VW'(k));
  endtask

  vec_t vecs [7];

  initial begin
    logic [MOD_LEN-1:0] rx, ones, big;
    modn = '1;
    modn = modn - MOD_LEN'(158);
    for (int i = 0; i < 32; i++) rx[i*32 +: 32] = $urandom;
    ones = '1;
    big  = '0;
    big[MOD_LEN-1] = 1'b1;

    vecs[0] = '{"sq3_t2",    MOD_LEN'(3),      64'd2,   VW'(81)};
    vecs[1] = '{"zero_iter", MOD_LEN'(16'h1234), 64'd0, VW'(16'h1234)};
    vecs[2] = '{"two_t5",    MOD_LEN'(2),      64'd5,   VW'(64'h1_0000_0000)};
    vecs[3] = '{"ffff_t1",   MOD_LEN'(16'hFFFF), 64'd1, VW'(32'hFFFE_0001)};
    vecs[4] = '{"ones_t0",   ones,             64'd0,   VW'(ones)};
    vecs[5] = '{"big_t3",    big,              64'd3,   VW'(pow2k(big, 3))};
    vecs[6] = '{"rand_t100", rx,               64'd100, VW'(pow2k(rx, 100))};

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.sq_in   = '0;
    bus.t_iters = '0;
`ifdef MSW_ABORT_EN
    bus.abort   = 1'b0;
`endif
    mon_exp = '0; mon_k = 0; mon_done = 0; mon_late = 0; mon_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", VW'(bus.busy), VW'(0));
    check("rst_valid", VW'(bus.sq_out_valid), VW'(0));
    check("rst_done", VW'(bus.done), VW'(0));
    check("rst_iter_count", VW'(bus.iter_count), VW'(0));
    check("rst_sq_out", decode_out(bus.sq_out), VW'(0));
    check("rst_core_reset", VW'(core_reset), VW'(1));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].x, vecs[i].t);
      finish_run(vecs[i].name, vecs[i].t, vecs[i].exp_final);
    end

    // Second start mid-run is ignored
    launch(MOD_LEN'(5), 64'd20);
    wait_k(5);
    bus.sq_in   = MOD_LEN'(9);
    bus.t_iters = 64'd3;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    finish_run("restart_ignored", 64'd20, VW'(pow2k(MOD_LEN'(5), 20)));

    // Reset mid-run clears everything; start during reset is ignored
    launch(MOD_LEN'(11), 64'd20);
    wait_k(7);
    reset       = 1'b1;
    bus.start   = 1'b1;
    bus.sq_in   = MOD_LEN'(4);
    bus.t_iters = 64'd5;
    tick();
    bus.start = 1'b0;
    check("midrst_busy", VW'(bus.busy), VW'(0));
    check("midrst_valid", VW'(bus.sq_out_valid), VW'(0));
    check("midrst_done", VW'(bus.done), VW'(0));
    check("midrst_iter_count", VW'(bus.iter_count), VW'(0));
    check("midrst_sq_out", decode_out(bus.sq_out), VW'(0));
    reset = 1'b0;
    tick();
    tick();
    check("rst_start_ignored", VW'(bus.busy), VW'(0));
    launch(MOD_LEN'(6), 64'd3);
    finish_run("after_reset", 64'd3, VW'(1679616));

`ifdef MSW_ABORT_EN
    // Abort mid-run: no done, counters and result hold
    launch(MOD_LEN'(3), 64'd10);
    wait_k(4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", VW'(bus.busy), VW'(0));
    repeat (20) tick();
    check("abort_no_done", VW'(mon_done), VW'(0));
    check("abort_iter_count", VW'(bus.iter_count), VW'(4));
    check("abort_valid_count", VW'(mon_k), VW'(4));
    check("abort_sq_out", decode_out(bus.sq_out), VW'(pow2k(MOD_LEN'(3), 4)));
    launch(MOD_LEN'(3), 64'd2);
    finish_run("after_abort", 64'd2, VW'(81));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
